// File: rtl/frame_rd_stream.sv
// Streams one frame of 32-bit words from external memory to the HDMI pixel path.
// Reads are credit-limited so that the 2**FIFO_AW-deep pixel FIFO can never overflow.
module frame_rd_stream #(
    parameter logic [28:0] BASE_ADDR = 29'd0,
    parameter int unsigned FRAME_PIX = 307200,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic        clk_25_2m,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        ram_rdy,
    input  logic        avl_ready,
    output logic        avl_read_req,
    output logic [28:0] avl_addr,
    input  logic        rd_data_valid,
    input  logic [31:0] rd_data,
    input  logic        pix_req,
    output logic [23:0] pix_data,
    output logic        frame_done,
    output logic        underflow
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned SW    = FIFO_AW + 2;
    localparam int unsigned RCW   = 20;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t r_state, w_state_nxt;

    logic [23:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr, r_rd;
    logic [CW-1:0]      r_cnt, r_out, r_disc;
    logic [RCW-1:0]     r_reqcnt, r_pixcnt;

    logic           w_start, w_accept, w_drop, w_ret, w_push, w_pop;
    logic           w_last_acc, w_drained, w_req_nxt, w_unused;
    logic [CW-1:0]  w_out_step, w_disc_step, w_cnt_nxt, w_out_nxt, w_disc_nxt;
    logic [RCW-1:0] w_reqcnt_nxt;
    logic [SW-1:0]  w_credit_nxt;

    // A start from IDLE needs calibrated memory; in FETCH/DRAIN it is an abort-and-restart.
    assign w_start    = frame_start && ((r_state != IDLE) || ram_rdy);
    assign w_accept   = avl_read_req && avl_ready;
    assign w_drop     = rd_data_valid && (r_disc != '0);
    assign w_ret      = rd_data_valid && (r_disc == '0);
    assign w_push     = w_ret && !w_start;
    assign w_pop      = pix_req && (r_cnt != '0);
    assign w_last_acc = w_accept && (r_reqcnt == RCW'(FRAME_PIX - 1));
    assign w_drained  = (r_out == '0) && (r_disc == '0) && (r_cnt == '0)
                        && (r_pixcnt == RCW'(FRAME_PIX));
    assign w_unused   = &{1'b0, rd_data[31:24]};

    // Words still in flight at a restart become discards so stale data never reaches the FIFO.
    assign w_out_step   = r_out + CW'(w_accept) - CW'(w_ret);
    assign w_disc_step  = r_disc - CW'(w_drop);
    assign w_out_nxt    = w_start ? '0 : w_out_step;
    assign w_disc_nxt   = w_start ? (w_disc_step + w_out_step) : w_disc_step;
    assign w_cnt_nxt    = w_start ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));
    assign w_reqcnt_nxt = w_start ? '0 : (r_reqcnt + RCW'(w_accept));
    assign w_credit_nxt = SW'(w_cnt_nxt) + SW'(w_out_nxt) + SW'(w_disc_nxt);
    assign w_req_nxt    = (w_state_nxt == FETCH) && (w_credit_nxt < SW'(DEPTH))
                          && (w_reqcnt_nxt < RCW'(FRAME_PIX));

    always_ff @(posedge clk_25_2m) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = FETCH;
            FETCH:   if (w_start) w_state_nxt = FETCH;
                     else if (w_last_acc) w_state_nxt = DRAIN;
            DRAIN:   if (w_start) w_state_nxt = FETCH;
                     else if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request, FIFO and pixel-side registers.
    always_ff @(posedge clk_25_2m) begin
        if (!reset) begin
            avl_read_req <= 1'b0;
            avl_addr     <= BASE_ADDR;
            r_cnt        <= '0;
            r_out        <= '0;
            r_disc       <= '0;
            r_reqcnt     <= '0;
            r_pixcnt     <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            pix_data     <= 24'h000000;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            avl_read_req <= w_req_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out        <= w_out_nxt;
            r_disc       <= w_disc_nxt;
            r_reqcnt     <= w_reqcnt_nxt;
            frame_done   <= w_pop && !w_start && (r_pixcnt == RCW'(FRAME_PIX - 1));

            if (w_start)       avl_addr <= BASE_ADDR;
            else if (w_accept) avl_addr <= avl_addr + 29'd1;

            if (w_start) begin
                r_wr     <= '0;
                r_rd     <= '0;
                r_pixcnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + FIFO_AW'(1);
                if (w_pop) begin
                    r_rd     <= r_rd + FIFO_AW'(1);
                    r_pixcnt <= r_pixcnt + RCW'(1);
                end
            end

            if (w_pop) begin
                pix_data <= r_mem[r_rd];
            end else if (pix_req) begin
                pix_data  <= 24'h000000;
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25_2m) begin
        if (w_push) r_mem[r_wr] <= rd_data[23:0];
    end

endmodule

// File: tb/tb_frame_rd_stream.sv
// Directed bench for frame_rd_stream: an 8-pixel instance for most scenarios and a
// 64-pixel instance for the read-credit limit, both fed by a fixed-latency memory model.
module tb_frame_rd_stream;
    logic clk_25_2m = 1'b0;
    always #20 clk_25_2m = ~clk_25_2m;

    logic reset = 1'b0, frame_start = 1'b0, ram_rdy = 1'b0, avl_ready = 1'b1, pix_req = 1'b0;
    logic [1:0]        req, done, uf;
    logic [1:0]        vld = '0;
    logic [1:0][28:0]  addr;
    logic [1:0][31:0]  rdat = '0;
    logic [1:0][23:0]  pix;

    int checks = 0, failures = 0;
    int cyc = 0, lat = 3, acc0 = 0, acc1 = 0;
    logic [7:0] tag = 8'h00;

    frame_rd_stream #(.BASE_ADDR(29'd0), .FRAME_PIX(8), .FIFO_AW(4)) u_dut (
        .clk_25_2m(clk_25_2m), .reset(reset), .frame_start(frame_start), .ram_rdy(ram_rdy),
        .avl_ready(avl_ready), .avl_read_req(req[0]), .avl_addr(addr[0]),
        .rd_data_valid(vld[0]), .rd_data(rdat[0]), .pix_req(pix_req), .pix_data(pix[0]),
        .frame_done(done[0]), .underflow(uf[0]));

    frame_rd_stream #(.BASE_ADDR(29'd0), .FRAME_PIX(64), .FIFO_AW(4)) u_dut_big (
        .clk_25_2m(clk_25_2m), .reset(reset), .frame_start(frame_start), .ram_rdy(ram_rdy),
        .avl_ready(avl_ready), .avl_read_req(req[1]), .avl_addr(addr[1]),
        .rd_data_valid(vld[1]), .rd_data(rdat[1]), .pix_req(pix_req), .pix_data(pix[1]),
        .frame_done(done[1]), .underflow(uf[1]));

    always @(posedge clk_25_2m) cyc <= cyc + 1;

    // Memory model: returns {8'hA5, tag at accept time, addr[15:0]} lat cycles after acceptance.
    typedef struct packed { logic [28:0] a; logic [7:0] t; int due; } rd_t;
    rd_t q0[$], q1[$];

    always @(negedge clk_25_2m) begin : mem_model
        rd_t e;
        vld = '0;
        if (!reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req[0] && avl_ready) begin
                e.a = addr[0]; e.t = tag; e.due = cyc + lat; q0.push_back(e); acc0++;
            end
            if (req[1] && avl_ready) begin
                e.a = addr[1]; e.t = tag; e.due = cyc + lat; q1.push_back(e); acc1++;
            end
            if (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front(); vld[0] = 1'b1; rdat[0] = {8'hA5, e.t, e.a[15:0]};
            end
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front(); vld[1] = 1'b1; rdat[1] = {8'hA5, e.t, e.a[15:0]};
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_25_2m);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Pops n pixels, expecting {tg, i} in order with frame_done only on the last one.
    task automatic drain_pixels(input string name, input logic [7:0] tg, input int n);
        for (int i = 0; i < n; i++) begin
            pix_req = 1'b1;
            step();
            chk({name, "_pix"}, 32'(pix[0]), 32'({tg, 16'(i)}));
            chk({name, "_done"}, 32'(done[0]), 32'(i == n - 1));
        end
        pix_req = 1'b0;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base, guard, exp_a;
        logic p_req, p_rdy;
        logic [28:0] p_addr;

        // Reset values
        step(3);
        reset = 1'b1;
        chk("rst_req", 32'(req[0]), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_pix", 32'(pix[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_uf", 32'(uf[0]), 32'd0);

        // frame_start without calibrated memory is ignored
        base = acc0;
        pulse_start();
        step(4);
        chk("norady_req", 32'(req[0]), 32'd0);
        chk("norady_acc", 32'(acc0 - base), 32'd0);

        // Basic frame, 3-cycle latency, data = address
        ram_rdy = 1'b1;
        lat = 3;
        tag = 8'h00;
        pulse_start();
        step(16);
        drain_pixels("basic", 8'h00, 8);
        step();
        chk("basic_done_clr", 32'(done[0]), 32'd0);
        chk("basic_pix_hold", 32'(pix[0]), 32'h7);
        chk("basic_uf", 32'(uf[0]), 32'd0);

        // Backpressure: avl_ready alternates; held request, no address skipped or repeated
        step(2);
        pulse_start();
        exp_a = 0;
        for (int k = 0; k < 24; k++) begin
            avl_ready = (k % 2 == 0);
            p_req = req[0];
            p_addr = addr[0];
            p_rdy = avl_ready;
            step();
            if (p_req && !p_rdy) begin
                chk("bp_hold_req", 32'(req[0]), 32'd1);
                chk("bp_hold_addr", 32'(addr[0]), 32'(p_addr));
            end
            if (p_req && p_rdy) begin
                chk("bp_acc_addr", 32'(p_addr), 32'(exp_a));
                exp_a++;
            end
        end
        avl_ready = 1'b1;
        chk("bp_total", 32'(exp_a), 32'd8);
        step(6);
        drain_pixels("bp", 8'h00, 8);
        step(2);

        // Credit limit on the 64-pixel instance: 40-cycle latency, no pixel consumption
        lat = 40;
        tag = 8'h03;
        pulse_start();
        base = acc1 - 0;
        base = acc1;
        step(30);
        chk("credit_acc30", 32'(acc1 - base), 32'd16);
        chk("credit_req30", 32'(req[1]), 32'd0);
        step(30);
        chk("credit_acc60", 32'(acc1 - base), 32'd16);
        chk("credit_req60", 32'(req[1]), 32'd0);

        // Underflow right after a restart
        lat = 3;
        tag = 8'h00;
        chk("uf_pre_pix", 32'(pix[0]), 32'h7);
        pulse_start();
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        chk("uf_pix", 32'(pix[0]), 32'd0);
        chk("uf_set", 32'(uf[0]), 32'd1);
        step(5);
        chk("uf_sticky", 32'(uf[0]), 32'd1);

        // Reset for one cycle in the middle of FETCH
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst_req", 32'(req[0]), 32'd0);
        chk("mrst_addr", 32'(addr[0]), 32'd0);
        chk("mrst_pix", 32'(pix[0]), 32'd0);
        chk("mrst_done", 32'(done[0]), 32'd0);
        chk("mrst_uf", 32'(uf[0]), 32'd0);
        base = acc0;
        step(10);
        chk("mrst_idle_req", 32'(req[0]), 32'd0);
        chk("mrst_idle_acc", 32'(acc0 - base), 32'd0);

        // Mid-frame restart with exactly five reads outstanding
        lat = 8;
        tag = 8'h01;
        pulse_start();
        base = acc0;
        guard = 0;
        while ((acc0 - base) < 5 && guard < 20) begin
            step();
            guard++;
        end
        avl_ready = 1'b0;
        chk("rs_outstanding", 32'(acc0 - base), 32'd5);
        tag = 8'h02;
        pulse_start();
        avl_ready = 1'b1;
        chk("rs_addr_base", 32'(addr[0]), 32'd0);
        step(25);
        drain_pixels("rs", 8'h02, 8);
        chk("rs_uf", 32'(uf[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_rd_stream.md
FRAME_RD_STREAM -- requirements
Module: frame_rd_stream

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BASE_ADDR, 29'd0, first word address of the frame.
- FRAME_PIX, 307200, pixels (32-bit words) per frame (640x480).
- FIFO_AW, 4, log2 pixel FIFO depth (depth 16).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_25_2m, in, 1, pixel clock; all logic on rising edge.
- reset, in, 1, synchronous, active-low.
- frame_start, in, 1, one-cycle pulse at start of vertical blanking; (re)starts a frame fetch.
- ram_rdy, in, 1, memory calibration done.
- avl_ready, in, 1, memory port accepts a request this cycle.
- avl_read_req, out, 1, read request.
- avl_addr, out, 29, read word address.
- rd_data_valid, in, 1, rd_data carries a returned word.
- rd_data, in, 32, read return data; pixel in [23:0].
- pix_req, in, 1, HDMI data-enable; one pixel consumed per asserted cycle.
- pix_data, out, 24, RGB pixel to HDMI.
- frame_done, out, 1, one-cycle pulse when the last pixel of the frame is output.
- underflow, out, 1, sticky; pix_req was seen with the FIFO empty.
REQ-003 Reset SHALL be reset, synchronous, active-low; the clock SHALL be clk_25_2m.

Function
REQ-004 States SHALL be IDLE, FETCH, DRAIN.
REQ-005 IDLE -> FETCH SHALL occur on frame_start=1 with ram_rdy=1. On this transition the block SHALL:
- clear the FIFO;
- set the request counter to 0 and avl_addr to BASE_ADDR.
REQ-006 frame_start with ram_rdy=0 SHALL be ignored, and the state SHALL remain IDLE.
REQ-007 In FETCH, avl_read_req SHALL assert when fifo_count + outstanding < 2**FIFO_AW and request counter < FRAME_PIX.
REQ-008 A request SHALL count as accepted only on a cycle where avl_read_req=1 and avl_ready=1.
REQ-009 While not accepted, avl_read_req and avl_addr SHALL be held stable.
REQ-010 On acceptance, the block SHALL:
- increment avl_addr by 1;
- increment the request counter by 1;
- increment outstanding by 1.
REQ-011 rd_data_valid=1 SHALL push rd_data[23:0] into the FIFO and decrement outstanding.
REQ-012 Simultaneous accept and return SHALL leave outstanding unchanged.
REQ-013 Read latency is unbounded. The credit rule in REQ-007 SHALL guarantee the FIFO never overflows.
REQ-014 FETCH -> DRAIN SHALL occur on the cycle the FRAME_PIX-th request is accepted.
REQ-015 DRAIN -> IDLE SHALL occur when outstanding=0, the FIFO is empty and the last pixel has been output.
REQ-016 pix_req=1 with the FIFO non-empty SHALL pop the head; pix_data SHALL present it on the next cycle (latency 1).
REQ-017 pix_req=1 with the FIFO empty SHALL drive pix_data=24'h000000 on the next cycle and set underflow.
REQ-018 underflow SHALL clear only on reset.
REQ-019 pix_data SHALL hold its last value when pix_req=0.
REQ-020 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo 2**FIFO_AW.
REQ-021 frame_done SHALL pulse for one cycle, concurrent with the FRAME_PIX-th pixel appearing on pix_data.
REQ-022 frame_start in FETCH or DRAIN SHALL abort and restart the frame:
- clear the FIFO and restart addressing at BASE_ADDR;
- load a discard counter with the current outstanding;
- drop the next (discard count) rd_data_valid words without pushing them.
REQ-023 While discard counter > 0, outstanding in REQ-007 SHALL include the discard count.
REQ-024 Width rules: the request counter SHALL be 20 bits; avl_addr SHALL wrap naturally at 2**29.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL enter IDLE with every output at 0:
- avl_read_req=0, avl_addr=BASE_ADDR;
- pix_data=24'h0, frame_done=0, underflow=0.
REQ-026 Reset SHALL also clear the FIFO, outstanding, discard and request counters, regardless of state.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Basic frame: FRAME_PIX=8, avl_ready=1, fixed 3-cycle read latency, data=i, pix_req for 8 cycles after 16 cycles -> pix_data 0..7 in order, frame_done with 7, underflow=0.
- Backpressure: avl_ready toggled 1/0 -> avl_addr and avl_read_req held while avl_ready=0; no address skipped or repeated.
- Credit limit: latency 40 cycles, pix_req=0 -> outstanding + fifo_count never exceeds 16, and avl_read_req deasserts at 16.
- Underflow: pix_req=1 immediately after frame_start -> pix_data=24'h0 next cycle, underflow=1 and remains 1.
- Mid-frame restart: frame_start with 5 reads outstanding -> 5 returns dropped, next pixel is word at BASE_ADDR.
- Reset mid-FETCH: reset=0 for one cycle -> all outputs 0, state IDLE, no request until next frame_start.
